// File: rtl/wb_byte_master_if.sv
// wb_byte_master_if: Wishbone B4 pipelined single-master bus bundle.
// Ports: master drives cyc/stb/we/adr/dat_o/sel and samples dat_i/ack/err/stall;
//        slave is the mirror image.
interface wb_byte_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;
  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/wb_byte_master.sv
// wb_byte_master: UART byte-stream command frames to single Wishbone B4 pipelined cycles.
// Ports: clk, rst_n (async active-low); rx_data/rx_valid byte input (no backpressure);
//        tx_data/tx_valid/tx_ready byte output; wb master bus; overrun_o dropped-byte pulse.
module wb_byte_master #(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  wb_byte_master_if.master  wb,
  output logic              overrun_o
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, WAIT, RESP} state_t;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  state_t          state_q;
  logic            cyc_q, stb_q, we_q, tx_valid_q, overrun_q;
  logic [3:0]      sel_q;
  logic [31:0]     adr_q, dat_q;
  logic [2:0]      bcnt_q;
  logic [TW-1:0]   tcnt_q;
  logic [7:0]      tx_data_q;
  logic            hit, tmo;
  // ack/err are honoured in WAIT or in the accept cycle itself, never while stalled
  assign hit = (state_q == WAIT || !wb.wb_stall_i) && (wb.wb_ack_i || wb.wb_err_i);
  // cyc is held for exactly TIMEOUT cycles when nothing answers
  assign tmo = tcnt_q == T_LAST;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign overrun_o   = overrun_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      adr_q      <= '0;
      dat_q      <= '0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= rx_valid && (state_q == REQ || state_q == WAIT || state_q == RESP);
      case (state_q)
        IDLE: if (rx_valid) begin
          bcnt_q <= '0;
          we_q   <= rx_data == 8'h01;
          if (rx_data == 8'h01 || rx_data == 8'h02) state_q <= ADDR;
          else begin
            tx_data_q  <= 8'hFF;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        ADDR: if (rx_valid) begin
          bcnt_q <= bcnt_q + 3'd1;
          adr_q  <= {rx_data, adr_q[31:8]};
          if (bcnt_q == 3'd3) begin
            adr_q   <= {rx_data, adr_q[31:10], 2'b00};
            bcnt_q  <= '0;
            state_q <= we_q ? WDATA : REQ;
            cyc_q   <= !we_q;
            stb_q   <= !we_q;
            sel_q   <= we_q ? 4'h0 : 4'hF;
            tcnt_q  <= '0;
          end
        end
        WDATA: if (rx_valid) begin
          bcnt_q <= bcnt_q + 3'd1;
          dat_q  <= {rx_data, dat_q[31:8]};
          if (bcnt_q == 3'd3) begin
            state_q <= REQ;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            sel_q   <= 4'hF;
            tcnt_q  <= '0;
          end
        end
        REQ, WAIT: begin
          if (tcnt_q != T_MAX) tcnt_q <= tcnt_q + TW'(1);
          if (state_q == REQ && !wb.wb_stall_i) begin
            stb_q   <= 1'b0;
            state_q <= WAIT;
          end
          if (hit || tmo) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            sel_q      <= 4'h0;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
            tx_data_q  <= (hit && wb.wb_err_i) ? 8'hEE : hit ? 8'h00 : 8'hE0;
            bcnt_q     <= (hit && !wb.wb_err_i && !we_q) ? 3'd4 : 3'd0;
            if (hit && !we_q) dat_q <= wb.wb_dat_i;
          end
        end
        RESP: if (tx_ready) begin
          if (bcnt_q == 3'd0) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            tx_data_q <= dat_q[7:0];
            dat_q     <= {8'h00, dat_q[31:8]};
            bcnt_q    <= bcnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_byte_master.sv
// tb_wb_byte_master: directed self-checking bench for wb_byte_master with TIMEOUT=16.
module tb_wb_byte_master;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       overrun_o;
  int         n_cmp = 0;
  int         n_err = 0;
  wb_byte_master_if bus ();
  wb_byte_master #(.TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb(bus), .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic take_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, tx_valid, 1);
    chk(tag, tx_data, exp);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask
  initial begin
    int n;
    bus.wb_dat_i = '0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_stall_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_stb", bus.wb_stb_o, 0);
    chk("rst_we", bus.wb_we_o, 0);
    chk("rst_adr", bus.wb_adr_o, 0);
    chk("rst_dat", bus.wb_dat_o, 0);
    chk("rst_sel", bus.wb_sel_o, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_ovr", overrun_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // write frame, ack one cycle after accept
    send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h10);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("wr_stb", bus.wb_stb_o, 1);
    chk("wr_cyc", bus.wb_cyc_o, 1);
    chk("wr_adr", bus.wb_adr_o, 32'h1000_0010);
    chk("wr_dat", bus.wb_dat_o, 32'hDEAD_BEEF);
    chk("wr_we", bus.wb_we_o, 1);
    chk("wr_sel", bus.wb_sel_o, 4'hF);
    @(negedge clk);
    chk("wr_stb_drop", bus.wb_stb_o, 0);
    chk("wr_cyc_hold", bus.wb_cyc_o, 1);
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("wr_cyc_end", bus.wb_cyc_o, 0);
    chk("wr_txv_lat", tx_valid, 1);
    take_tx("wr_status", 8'h00);
    chk("wr_tx_done", tx_valid, 0);
    // read frame, three stall cycles then ack, with tx backpressure
    send(8'h02); send(8'h00); send(8'h01); send(8'h00);
    bus.wb_stall_i = 1'b1;
    send(8'h00);
    repeat (3) begin
      chk("rd_stb_stalled", bus.wb_stb_o, 1);
      @(negedge clk);
    end
    bus.wb_stall_i = 1'b0;
    chk("rd_stb_accept", bus.wb_stb_o, 1);
    chk("rd_adr", bus.wb_adr_o, 32'h0000_0100);
    chk("rd_we", bus.wb_we_o, 0);
    @(negedge clk);
    chk("rd_stb_drop", bus.wb_stb_o, 0);
    chk("rd_cyc_hold", bus.wb_cyc_o, 1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h1234_5678;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    chk("rd_cyc_end", bus.wb_cyc_o, 0);
    take_tx("rd_status", 8'h00);
    take_tx("rd_b0", 8'h78);
    repeat (10) begin
      chk("bp_txv", tx_valid, 1);
      chk("bp_txd", tx_data, 8'h56);
      @(negedge clk);
    end
    take_tx("rd_b1", 8'h56);
    take_tx("rd_b2", 8'h34);
    take_tx("rd_b3", 8'h12);
    chk("rd_tx_done", tx_valid, 0);
    // ack and err together in the accept cycle: err wins, no data bytes
    send(8'h02); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    chk("err_cyc", bus.wb_cyc_o, 0);
    take_tx("err_status", 8'hEE);
    chk("err_tx_done", tx_valid, 0);
    // timeout on a read that is never answered
    send(8'h02); send(8'h08); send(8'h00); send(8'h00); send(8'h00);
    n = 0;
    while (bus.wb_cyc_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 16);
    take_tx("to_status", 8'hE0);
    chk("to_tx_done", tx_valid, 0);
    send(8'h01); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    chk("wr2_adr", bus.wb_adr_o, 32'h0000_0020);
    chk("wr2_dat", bus.wb_dat_o, 32'h1122_3344);
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("wr2_cyc_end", bus.wb_cyc_o, 0);
    take_tx("wr2_status", 8'h00);
    // unknown command
    send(8'h7A);
    take_tx("bad_status", 8'hFF);
    chk("bad_tx_done", tx_valid, 0);
    // bytes arriving during WAIT are dropped with an overrun pulse each
    send(8'h02); send(8'h0C); send(8'h00); send(8'h00); send(8'h00);
    @(negedge clk);
    chk("ovr_idle", overrun_o, 0);
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("ovr_p1", overrun_o, 1);
    rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("ovr_p2", overrun_o, 1);
    @(negedge clk);
    chk("ovr_clear", overrun_o, 0);
    chk("ovr_cyc", bus.wb_cyc_o, 1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    take_tx("ovr_status", 8'h00);
    take_tx("ovr_b0", 8'h0D);
    take_tx("ovr_b1", 8'hF0);
    take_tx("ovr_b2", 8'hFE);
    take_tx("ovr_b3", 8'hCA);
    chk("ovr_tx_done", tx_valid, 0);
    // reset in the middle of WAIT
    send(8'h02); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
    @(negedge clk);
    chk("rstw_cyc_pre", bus.wb_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_cyc", bus.wb_cyc_o, 0);
    chk("rstw_stb", bus.wb_stb_o, 0);
    chk("rstw_txv", tx_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_no_resp", tx_valid, 0);
    chk("rstw_cyc_idle", bus.wb_cyc_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
- Byte-stream-to-Wishbone bridge: decodes command frames from a UART receiver byte stream and issues single 32-bit Wishbone B4 pipelined read/write cycles as a bus initiator.
- Returns status and read data as a byte stream to a UART transmitter.
- Attaches to the shared-bus interconnect as an additional master alongside the core and debug module, giving host-side memory/peripheral access without JTAG.

Parameters:
- TIMEOUT, 1024, cycles from cyc assertion to abandoning a bus cycle; must be >= 2.
- TW, 11, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe that rx_data is valid; there is no backpressure.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data valid; held until accepted.
- tx_ready  input  1  transmitter accepts the byte when tx_valid && tx_ready.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_stb_o  output  1  Wishbone strobe.
- wb_we_o  output  1  write enable.
- wb_adr_o  output  32  byte address, bits [1:0] forced to 0.
- wb_dat_o  output  32  write data.
- wb_sel_o  output  4  byte selects, always 4'hF during a cycle.
- wb_dat_i  input  32  read data.
- wb_ack_i  input  1  acknowledge.
- wb_err_i  input  1  error.
- wb_stall_i  input  1  pipelined stall.
- overrun_o  output  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (async assert, sync deassert by upstream): state IDLE; cyc/stb/we/tx_valid/overrun_o = 0; adr/dat_o/tx_data = 0; sel = 0.
- Frame format:
  - Byte0 is cmd: 0x01 write, 0x02 read.
  - Followed by 4 address bytes, LSB first.
  - Write frames add 4 data bytes, LSB first.
- States: IDLE, ADDR, WDATA, REQ, WAIT, RESP.
- IDLE:
  - rx_valid with 0x01/0x02 -> ADDR, byte counter = 0.
  - Any other cmd -> queue status 0xFF, go to RESP.
- ADDR: each rx_valid shifts a byte in. After the 4th byte -> WDATA (write) or REQ (read).
- WDATA: after the 4th byte -> REQ.
- REQ:
  - Assert cyc=1, stb=1, sel=F, and we per cmd; timeout counter starts at 0.
  - stb stays high while wb_stall_i=1.
  - The cycle with stb && !stall is the accept cycle; stb drops next cycle -> WAIT.
  - ack/err arriving in the accept cycle is honoured.
- WAIT: cyc held until one of:
  - ack -> status 0x00.
  - err -> status 0xEE.
  - Counter reaches TIMEOUT -> status 0xE0.
  - ack and err together -> err wins.
  - On any of these, cyc=0 next cycle; capture wb_dat_i on ack for reads.
- Timeout counter: runs in both REQ and WAIT, so a permanently stalled REQ also times out. Counter saturates and does not wrap.
- RESP:
  - Sends the status byte.
  - Then, for reads with status 0x00 only, sends 4 data bytes LSB first.
  - Each byte is presented with tx_valid=1 and held stable until tx_ready. Next byte (or deassert) follows the cycle after the handshake, so throughput is one byte per handshake.
  - tx_valid=1 && tx_ready=1 on the last byte -> IDLE.
- Overrun: rx_valid while in REQ, WAIT or RESP drops the byte and pulses overrun_o for 1 cycle. Frame state is unaffected.
- No inter-byte timeout: a partial frame waits indefinitely.
- Reset mid-cycle: cyc/stb drop immediately (async); no response is sent.
- Latency:
  - Last frame byte -> stb high: 1 cycle.
  - ack -> tx_valid high: 1 cycle.

Test Plan:
- Write: frame 01 10 00 00 10 EF BE AD DE, no stall, ack 1 cycle after accept.
  -> one stb with adr=0x10000010, dat_o=0xDEADBEEF, we=1, sel=F; tx bytes: 00.
- Read: frame 02 00 01 00 00, slave stalls 3 cycles then acks with 0x12345678.
  -> stb high for 4 cycles; tx bytes 00 78 56 34 12.
- Error/priority: read with ack and err asserted in the same cycle.
  -> tx byte EE only; cyc low the next cycle.
- Timeout: TIMEOUT=16, read with no ack.
  -> cyc deasserts after 16 cycles; tx byte E0 only; a following write frame completes normally.
- Bad cmd + overrun: cmd 0x7A -> tx FF. Bytes sent during WAIT -> overrun_o pulses per byte and the pending response is intact.
- Backpressure/reset: hold tx_ready=0 for 10 cycles mid-read-response -> tx_data stable throughout. Assert rst_n=0 during WAIT -> cyc=0 and tx_valid=0 immediately.
